// File: rtl/alu_op_decoder.sv
// alu_op_decoder: registered RV32I decode/issue stage in front of the ALU.
// Accepts an instruction word with its PC and register read data, and issues
// an ALU operation, operands, destination register and an illegal flag.
//
// Handshake (both sides): a transfer happens on a rising clk_i edge where
// valid and ready are both high. A held output bundle does not change while
// out_valid_o=1 and out_ready_i=0. flush_i empties the stage on the next edge
// and takes priority over any transfer on that edge.
//
// Configuration macro: ALU_DEC_SKID_EN
//   defined   : two-entry skid buffer (EMPTY/ONE/TWO), registered in_ready_o.
//   undefined : single output register, in_ready_o = !out_valid_o || out_ready_i.
// dbg_state_o reports occupancy state (EMPTY=0, ONE=1, TWO=2).
module alu_op_decoder #(
    parameter int XLEN       = 32,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    output logic [4:0]            rd_addr_o,
    output logic                  illegal_instr_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9,
        ALU_OP_LUI  = 4'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e               op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [4:0]            rd;
        logic                  ill;
    } bundle_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Immediates are formed at 32 bits and sign-extended to the operand width.
    logic signed [31:0]    imm_i32, imm_s32, imm_u32, imm_j32;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_u, imm_j, shamt;

    assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u32 = {instr_i[31:12], 12'b0};
    assign imm_j32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    assign imm_i = DATA_WIDTH'(imm_i32);
    assign imm_s = DATA_WIDTH'(imm_s32);
    assign imm_u = DATA_WIDTH'(imm_u32);
    assign imm_j = DATA_WIDTH'(imm_j32);
    // Shift-immediates carry only the shift amount so the ALU sees a clean count.
    assign shamt = DATA_WIDTH'(instr_i[24:20]);

    // Map funct3 to the base (non-alternate) register/immediate ALU operation.
    alu_op_e base_op;
    always_comb begin
        base_op = ALU_OP_ADD;
        case (funct3)
            3'b000:  base_op = ALU_OP_ADD;
            3'b001:  base_op = ALU_OP_SLL;
            3'b010:  base_op = ALU_OP_SLT;
            3'b011:  base_op = ALU_OP_SLTU;
            3'b100:  base_op = ALU_OP_XOR;
            3'b101:  base_op = ALU_OP_SRL;
            3'b110:  base_op = ALU_OP_OR;
            default: base_op = ALU_OP_AND;
        endcase
    end

    // Combinational decode of the incoming bundle; only ever captured into registers.
    bundle_t dec;
    always_comb begin
        dec     = '0;
        dec.op  = ALU_OP_ADD;
        dec.rd  = instr_i[11:7];
        dec.ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.a = rs1_data_i;
                dec.b = rs2_data_i;
                if (funct7 == F7_BASE) begin
                    dec.op = base_op;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.op = ALU_OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.op = ALU_OP_SRA;
                end else begin
                    // Includes funct7 0000001: M-extension ops belong to the mul/div unit.
                    dec.ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.a  = rs1_data_i;
                dec.b  = imm_i;
                dec.op = base_op;
                if (funct3 == 3'b001) begin
                    dec.b = shamt;
                    if (funct7 != F7_BASE) dec.ill = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec.b = shamt;
                    if (funct7 == F7_BASE)     dec.op  = ALU_OP_SRL;
                    else if (funct7 == F7_ALT) dec.op  = ALU_OP_SRA;
                    else                       dec.ill = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.op = ALU_OP_LUI;
                dec.b  = imm_u;
            end
            OPC_AUIPC: begin
                dec.a = pc_i;
                dec.b = imm_u;
            end
            OPC_LOAD: begin
                dec.a = rs1_data_i;
                dec.b = imm_i;
            end
            OPC_STORE: begin
                dec.a = rs1_data_i;
                dec.b = imm_s;
            end
            OPC_JALR: begin
                dec.a = rs1_data_i;
                dec.b = imm_i;
                if (funct3 != 3'b000) dec.ill = 1'b1;
            end
            OPC_JAL: begin
                dec.a = pc_i;
                dec.b = imm_j;
            end
            OPC_BRANCH: begin
                dec.a = rs1_data_i;
                dec.b = rs2_data_i;
                case (funct3)
                    3'b000, 3'b001: dec.op  = ALU_OP_SUB;
                    3'b100, 3'b101: dec.op  = ALU_OP_SLT;
                    3'b110, 3'b111: dec.op  = ALU_OP_SLTU;
                    default:        dec.ill = 1'b1;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
        // Illegal bundles still issue, but with a neutral payload.
        if (dec.ill) begin
            dec.op = ALU_OP_ADD;
            dec.a  = '0;
            dec.b  = '0;
            dec.rd = '0;
        end
    end

    bundle_t main_q;
    logic    out_valid_q;
    logic    in_fire;
    logic    out_fire;

    assign out_fire = out_valid_q && out_ready_i;

`ifdef ALU_DEC_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e  state_q;
    bundle_t skid_q;
    logic    in_ready_q;

    assign in_fire = in_valid_i && in_ready_q;

    // Skid FSM: main_q drives the outputs, skid_q holds the second (younger) bundle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            main_q.op   <= ALU_OP_ADD;
            skid_q      <= '0;
        end else if (flush_i) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q      <= dec;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= dec;
                    end else if (in_fire) begin
                        skid_q     <= dec;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_TWO;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign dbg_state_o = state_q;
`else
    logic in_ready;

    assign in_ready = !out_valid_q || out_ready_i;
    assign in_fire  = in_valid_i && in_ready;

    // Single output register: load on accept, empty on transfer without refill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            main_q      <= '0;
            main_q.op   <= ALU_OP_ADD;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            main_q      <= dec;
            out_valid_q <= 1'b1;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready_o  = in_ready;
    assign dbg_state_o = {1'b0, out_valid_q};
`endif

    assign out_valid_o     = out_valid_q;
    assign alu_op_o        = main_q.op;
    assign operand_a_o     = main_q.a;
    assign operand_b_o     = main_q.b;
    assign rd_addr_o       = main_q.rd;
    assign illegal_instr_o = main_q.ill;

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: directed-vector bench for alu_op_decoder.
// Builds in either configuration (ALU_DEC_SKID_EN defined or not).
module tb_alu_op_decoder;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_LUI  = 4'd10;

`ifdef ALU_DEC_SKID_EN
    localparam int EXP_ACCEPT = 2;
`else
    localparam int EXP_ACCEPT = 1;
`endif

    localparam int NVEC = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_addr;
    logic        illegal;
    logic [1:0]  dbg_state;

    logic [73:0] got;
    assign got = {alu_op, op_a, op_b, rd_addr, illegal};

    int checks = 0;
    int errors = 0;

    logic [31:0] t_instr [NVEC];
    logic [31:0] t_pc    [NVEC];
    logic [31:0] t_rs1   [NVEC];
    logic [31:0] t_rs2   [NVEC];
    logic [73:0] t_exp   [NVEC];

    alu_op_decoder dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .instr_i         (instr),
        .pc_i            (pc),
        .rs1_data_i      (rs1),
        .rs2_data_i      (rs2),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .alu_op_o        (alu_op),
        .operand_a_o     (op_a),
        .operand_b_o     (op_b),
        .rd_addr_o       (rd_addr),
        .illegal_instr_o (illegal),
        .dbg_state_o     (dbg_state)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [73:0] mk(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd,
                                       input logic ill);
        return {op, a, b, rd, ill};
    endfunction

    task automatic set_vec(input int i, input logic [31:0] ins, input logic [31:0] p,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [73:0] e);
        t_instr[i] = ins; t_pc[i] = p; t_rs1[i] = r1; t_rs2[i] = r2; t_exp[i] = e;
    endtask

    task automatic init_table;
        set_vec(0,  32'h40315093, 32'h0,   32'h80000000, 32'h0, mk(OP_SRA, 32'h80000000, 32'd3, 5'd1, 1'b0));
        set_vec(1,  32'h123452B7, 32'h0,   32'h0000DEAD, 32'h0, mk(OP_LUI, 32'h0, 32'h12345000, 5'd5, 1'b0));
        set_vec(2,  32'h12345297, 32'h100, 32'h0,        32'h0, mk(OP_ADD, 32'h100, 32'h12345000, 5'd5, 1'b0));
        set_vec(3,  32'h40208233, 32'h0,   32'd10,       32'd3, mk(OP_SUB, 32'd10, 32'd3, 5'd4, 1'b0));
        set_vec(4,  32'h0020C063, 32'h0,   32'd1,        32'd2, mk(OP_SLT, 32'd1, 32'd2, 5'd0, 1'b0));
        set_vec(5,  32'h0020A423, 32'h0,   32'h1000,     32'd9, mk(OP_ADD, 32'h1000, 32'd8, 5'd8, 1'b0));
        set_vec(6,  32'h010000EF, 32'h200, 32'h0,        32'h0, mk(OP_ADD, 32'h200, 32'd16, 5'd1, 1'b0));
        set_vec(7,  32'hFFF00093, 32'h0,   32'h0,        32'h0, mk(OP_ADD, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b0));
        set_vec(8,  32'h0020A063, 32'h0,   32'd1,        32'd2, mk(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b1));
        set_vec(9,  32'hFFFFFFFF, 32'h0,   32'd3,        32'd4, mk(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b1));
        set_vec(10, 32'h022081B3, 32'h0,   32'd5,        32'd7, mk(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b1));
        set_vec(11, 32'hFFF0B313, 32'h0,   32'd1,        32'h0, mk(OP_SLTU, 32'd1, 32'hFFFFFFFF, 5'd6, 1'b0));
        set_vec(12, 32'h40209093, 32'h0,   32'd1,        32'h0, mk(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b1));
        set_vec(13, 32'h0020D2B3, 32'h0,   32'd20,       32'd2, mk(OP_SRL, 32'd20, 32'd2, 5'd5, 1'b0));
    endtask

    // Driver: present one bundle on the input side.
    task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        instr    = ins;
        pc       = p;
        rs1      = r1;
        rs2      = r2;
    endtask

    // Driver: one accepted bundle with downstream ready; returns 1 cycle later, sampling time.
    task automatic send(input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2);
        @(negedge clk);
        drive(ins, p, r1, r2);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; rs1 = '0; rs2 = '0;
        #3;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_handshake got %b exp 01", {out_valid, in_ready});
        end
        checks++;
        if (got !== mk(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset_bundle got %h exp %h", got, mk(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0));
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d exp 0", dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        send(32'h002081B3, 32'h0, 32'd5, 32'd7);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_valid got %b exp 1", out_valid);
        end
        checks++;
        if (got !== mk(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b0)) begin
            errors++;
            $display("FAIL add_bundle got %h exp %h", got, mk(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b0));
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drained got %b exp 0", out_valid);
        end
    endtask

    task automatic test_decode;
        for (int i = 0; i < NVEC; i++) begin
            send(t_instr[i], t_pc[i], t_rs1[i], t_rs2[i]);
            checks++;
            if (out_valid !== 1'b1 || got !== t_exp[i]) begin
                errors++;
                $display("FAIL decode_%0d got v=%b %h exp v=1 %h", i, out_valid, got, t_exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int c = 0; c <= NVEC; c++) begin
            @(negedge clk);
            if (c < NVEC) drive(t_instr[c], t_pc[c], t_rs1[c], t_rs2[c]);
            else          in_valid = 1'b0;
            #1;
            if (c < NVEC) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_%0d got %b exp 1", c, in_ready);
                end
            end
            if (c > 0) begin
                checks++;
                if (out_valid !== 1'b1 || got !== t_exp[c-1]) begin
                    errors++;
                    $display("FAIL b2b_out_%0d got v=%b %h exp v=1 %h", c - 1, out_valid, got, t_exp[c-1]);
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_stall;
        logic [73:0] exp_q [$];
        logic [73:0] snap;
        logic        snapped;
        logic        take;
        int          k;
        int          n;
        snapped = 1'b0;
        k = 0;
        n = 0;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(mk(OP_ADD, 32'h11 * (i + 1), 32'd7, 5'd3, 1'b0));
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (k < 3) drive(32'h002081B3, 32'h0, 32'h11 * (k + 1), 32'd7);
            else       in_valid = 1'b0;
            #1;
            take = in_valid && in_ready;
            if (out_valid) begin
                if (!snapped) begin
                    snap = got;
                    snapped = 1'b1;
                end else begin
                    checks++;
                    if (got !== snap) begin
                        errors++;
                        $display("FAIL stall_stable_%0d got %h exp %h", c, got, snap);
                    end
                end
            end
            @(posedge clk);
            if (take) k++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (k !== EXP_ACCEPT) begin
            errors++;
            $display("FAIL stall_accepted got %0d exp %0d", k, EXP_ACCEPT);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready got %b exp 0", in_ready);
        end
        // Release downstream and collect everything in order.
        for (int c = 0; c < 12 && n < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (k < 3) drive(32'h002081B3, 32'h0, 32'h11 * (k + 1), 32'd7);
            else       in_valid = 1'b0;
            #1;
            take = in_valid && in_ready;
            if (out_valid) begin
                checks++;
                if (got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stall_order_%0d got %h exp %h", n, got, exp_q[0]);
                end
                void'(exp_q.pop_front());
                n++;
            end
            @(posedge clk);
            if (take) k++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL stall_drain_count got %0d exp 3", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(32'h002081B3, 32'h0, 32'd40 + c, 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_prefill got %b exp 10", {out_valid, in_ready});
        end
        flush = 1'b1;
        drive(32'h002081B3, 32'h0, 32'd99, 32'd1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_cleared got %b exp 01", {out_valid, in_ready});
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stays_empty got %b exp 0", out_valid);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_prefill got %b exp 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || got !== mk(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0)) begin
            errors++;
            $display("FAIL arst_immediate got v=%b r=%b %h exp v=0 r=1 %h",
                     out_valid, in_ready, got, mk(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || got !== mk(OP_ADD, 32'd1, 32'd2, 5'd3, 1'b0)) begin
            errors++;
            $display("FAIL arst_first_transfer got v=%b %h exp v=1 %h",
                     out_valid, got, mk(OP_ADD, 32'd1, 32'd2, 5'd3, 1'b0));
        end
        @(negedge clk);
    endtask

    initial begin
        init_table();
        test_reset();
        test_add();
        test_decode();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
